// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings and stall vectors for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_RUN      = 2'd0,
        PC_MC_WAIT  = 2'd1,
        PC_MEM_WAIT = 2'd2
    } pc_state_t;

    // Bit order: [0] bubble ID/EX, [1] hold IF/ID, [2] hold PC, [3] freeze ID/EX and EX
    localparam logic [3:0] STALL_NONE   = 4'b0000;
    localparam logic [3:0] STALL_LD_USE = 4'b0111;
    localparam logic [3:0] STALL_FREEZE = 4'b1110;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating 32-bit event counters for stall and flush cycles (used only with PIPE_CTRL_PERF_EN).
module pipe_ctrl_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_active,
    input  logic        flush,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    logic [1:0]  event_vec;
    logic [31:0] cnt_reg [2];

    assign event_vec = {flush, stall_active};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg[gi] <= 32'h0;
                end else if (event_vec[gi] && (cnt_reg[gi] != 32'hFFFF_FFFF)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_stall_cnt = cnt_reg[0];
    assign perf_flush_cnt = cnt_reg[1];

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: merges ID/EX/MEM stall requests and EX branch into hold/flush.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_LEN_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_stallreq_i,
    input  logic                ex_mc_start_i,
    input  logic [MC_LEN_W-1:0] ex_mc_len_i,
    input  logic                mem_req_i,
    input  logic                mem_ack_i,
    input  logic                ex_branch_flag_i,
    output logic [3:0]          stalled_o,
    output logic                flush_o,
    output logic                mc_busy_o,
    output logic [31:0]         perf_stall_cnt_o,
    output logic [31:0]         perf_flush_cnt_o
);

    pc_state_t           state_reg, state_next;
    logic [MC_LEN_W-1:0] cnt_reg, cnt_next;
    logic [3:0]          stall_comb;
    logic                flush_comb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= PC_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_comb = STALL_NONE;
        flush_comb = 1'b0;
        case (state_reg)
            PC_RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    stall_comb = STALL_FREEZE;
                    state_next = PC_MEM_WAIT;
                end else if (ex_mc_start_i && (ex_mc_len_i >= MC_LEN_W'(2))) begin
                    // This cycle is the first frozen one, so the wait state covers len-1 more.
                    stall_comb = STALL_FREEZE;
                    cnt_next   = ex_mc_len_i - MC_LEN_W'(1);
                    state_next = PC_MC_WAIT;
                end else if (ex_mc_start_i) begin
                    stall_comb = STALL_NONE;
                end else if (ex_branch_flag_i) begin
                    flush_comb = 1'b1;
                end else if (id_stallreq_i) begin
                    stall_comb = STALL_LD_USE;
                end
            end
            PC_MC_WAIT: begin
                stall_comb = STALL_FREEZE;
                cnt_next   = cnt_reg - MC_LEN_W'(1);
                if (cnt_reg == MC_LEN_W'(1)) begin
                    state_next = PC_RUN;
                end
            end
            PC_MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_next = PC_RUN;
                end else begin
                    stall_comb = STALL_FREEZE;
                end
            end
            default: begin
                state_next = PC_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, regardless of inputs.
    assign stalled_o = rst ? stall_comb : STALL_NONE;
    assign flush_o   = rst ? flush_comb : 1'b0;
    assign mc_busy_o = rst && (state_reg == PC_MC_WAIT);

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .stall_active   (stalled_o != STALL_NONE),
        .flush          (flush_o),
        .perf_stall_cnt (perf_stall_cnt_o),
        .perf_flush_cnt (perf_flush_cnt_o)
    );
`else
    assign perf_stall_cnt_o = 32'h0;
    assign perf_flush_cnt_o = 32'h0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller for the five-stage core. It combines stall requests from ID (load-use), EX (fixed-latency multi-cycle ops) and MEM (bus wait) with the EX branch decision. From these it drives the stage-hold vector and flush consumed by the PC, IF/ID and ID/EX registers. It sits beside the datapath in the core top and owns a small FSM plus a multi-cycle countdown.

## Interface
Parameters:
- MC_LEN_W, 5, width of multi-cycle length field (max 31 cycles)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset (`RstEnable` = 1'b0)
- id_stallreq_i  in  1  load-use hazard detected in ID
- ex_mc_start_i  in  1  EX holds an op needing ex_mc_len_i cycles; level, held until accepted
- ex_mc_len_i  in  MC_LEN_W  total EX occupancy in cycles
- mem_req_i  in  1  MEM stage has an outstanding bus access
- mem_ack_i  in  1  bus completes access this cycle
- ex_branch_flag_i  in  1  EX redirects fetch this cycle
- stalled_o  out  4  [0] bubble into ID/EX, [1] hold IF/ID, [2] hold PC, [3] freeze ID/EX and EX
- flush_o  out  1  kill IF/ID and ID/EX contents
- mc_busy_o  out  1  state == MC_WAIT

## Operation
- States: RUN, MC_WAIT, MEM_WAIT; 5-bit down-counter cnt.
- Outputs are Mealy (state + current inputs), so consumers sample them at the same posedge.
- RUN, first true condition wins:
  - mem_req_i & ~mem_ack_i: stalled_o=4'b1110, next MEM_WAIT.
  - ex_mc_start_i & ex_mc_len_i>=2: stalled_o=4'b1110, cnt<=len-1, next MC_WAIT; op accepted.
  - ex_mc_start_i & len<=1: no stall; op accepted. EX drops the request the cycle after acceptance.
  - ex_branch_flag_i: flush_o=1, stalled_o=0.
  - id_stallreq_i: stalled_o=4'b0111 for this cycle only. No state change; ID re-raises it if the hazard persists.
  - else stalled_o=0.
- MC_WAIT:
  - stalled_o=4'b1110 and cnt decrements each cycle.
  - When cnt==1, next state is RUN.
  - Total frozen cycles equal ex_mc_len_i.
- MEM_WAIT:
  - stalled_o=4'b1110 while ~mem_ack_i.
  - On mem_ack_i, stalled_o=0 that cycle and next state is RUN.
- In MC_WAIT and MEM_WAIT:
  - ex_branch_flag_i and id_stallreq_i are ignored, because EX cannot resolve a branch while frozen.
  - flush_o=0.
- Branch and load-use in the same cycle: branch wins (the stalled instruction is being flushed).
- mem_req_i and ex_mc_start_i in the same cycle: MEM wins. The held mc request is accepted in the RUN cycle after the ack.

## Timing
- Reset (async, immediate): state RUN, cnt 0, stalled_o 0, flush_o 0, mc_busy_o 0, perf counters 0.
- Reset mid-MC_WAIT/MEM_WAIT aborts to RUN with outputs zero in the same cycle.
- Combinational latency input->stalled_o/flush_o: 0 cycles. State updates at posedge clk.
- mem_ack_i in the same cycle as mem_req_i in RUN: no stall cycle.
- Max length 31: freeze lasts 31 cycles, with cnt wrapping never reached.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - perf_stall_cnt_o[31:0] increments each cycle stalled_o != 0.
  - perf_flush_cnt_o[31:0] increments each cycle flush_o=1.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Not defined: both ports remain and are driven 32'h0. No counter flops are present.

## Structure
- bitty_defs.v gains the state encodings (`PC_RUN`, `PC_MC_WAIT`, `PC_MEM_WAIT`).
- It also gains the stall vectors: `StallNone` 4'b0000, `StallLdUse` 4'b0111, `StallFreeze` 4'b1110.
- One sub-module, pipe_ctrl_perf, holds the saturating counters. It is instantiated only under PIPE_CTRL_PERF_EN.

## Test plan
- id_stallreq_i=1 for 1 cycle in RUN -> stalled_o=4'b0111 that cycle only, then 0; state stays RUN.
- ex_mc_start_i, len=4 -> stalled_o=4'b1110 for exactly 4 cycles; mc_busy_o=1 for cycles 2–4; then RUN.
- mem_req_i held with mem_ack_i after 3 cycles -> 3 freeze cycles, 0 on the ack cycle. Same-cycle ack -> zero freeze.
- ex_branch_flag_i and id_stallreq_i together -> flush_o=1, stalled_o=0. With PERF_EN, flush count +1.
- mem_req_i and ex_mc_start_i (len=2) together -> MEM_WAIT until ack, then 2-cycle MC freeze.
- rst low during MC_WAIT (cnt=3) -> outputs 0 immediately; after release, state RUN and no residual freeze.
